// File: rtl/pio_bus_pkg.sv
// pio_bus_pkg: definitions shared by the PIO bus arbiter and the PIO blocks
// that decode the shared register bus.
//   arb_state_t     - arbiter FSM state (ST_IDLE=0, ST_OWNED=1)
//   PIO_ADDR_W/DATA - default register-bus address/data widths
//   next_rr_winner  - rotating-priority search, returns one-hot winner
package pio_bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  localparam int unsigned PIO_ADDR_W = 8;
  localparam int unsigned PIO_DATA_W = 8;

  // Largest supported requester count; the helper works on this width.
  localparam int unsigned RR_MAX_REQ = 8;

  localparam logic [7:0] BURST_SAT = 8'hFF;

  // Search upward from pointer+1, wrapping modulo num_req; the first set
  // request bit wins. Bits at or above num_req are ignored.
  function automatic logic [RR_MAX_REQ-1:0] next_rr_winner(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [2:0]            pointer,
    input int unsigned           num_req
  );
    logic [RR_MAX_REQ-1:0] win;
    logic [2:0]            idx;
    win = '0;
    for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
      if (k <= num_req) begin
        idx = 3'((32'(pointer) + k) % num_req);
        if (win == '0 && req[idx]) begin
          win[idx] = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/pio_rr_select.sv
// pio_rr_select: combinational rotating-priority encoder.
//   req     in  NUM_REQ  request vector
//   pointer in  PTR_W    index of the last granted requester
//   winner  out NUM_REQ  one-hot winner (0 when req is 0)
module pio_rr_select
  import pio_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner
);

  logic [RR_MAX_REQ-1:0] req_ext;
  logic [RR_MAX_REQ-1:0] win_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    win_ext              = next_rr_winner(req_ext, 3'(pointer), NUM_REQ);
    winner               = NUM_REQ'(win_ext);
  end

endmodule

// File: rtl/pio_bus_arbiter.sv
// pio_bus_arbiter: round-robin arbiter sharing one atmega_pio-style register
// bus between NUM_REQ requesters, with burst-length fairness and a registered
// one-cycle ack carrying captured read data.
//
// Ports:
//   clk, rst (sync, active-low)
//   req/req_wr/req_rd [NUM_REQ]      per-requester request and strobes
//   req_addr/req_wdat (packed)       slice i belongs to requester i
//   gnt/ack [NUM_REQ]                registered one-hot grant, ack pulse
//   rdat                             read data captured with ack
//   addr_dat/wr_dat/rd_dat/bus_dat_in  bus towards the PIO blocks
//   bus_dat_out                      combinational read data from PIO
//   timeout                          watchdog revoke pulse
//
// Optional build macro: PIO_ARB_TIMEOUT_EN enables the idle-grant watchdog;
// without it timeout is tied to 0 and a grant is held indefinitely.
module pio_bus_arbiter
  import pio_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 2,
  parameter int unsigned BUS_ADDR_DATA_LEN = PIO_ADDR_W,
  parameter int unsigned BUS_DATA_WIDTH    = PIO_DATA_W,
  parameter int unsigned MAX_BURST         = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ*BUS_ADDR_DATA_LEN-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                     req_wr,
  input  logic [NUM_REQ-1:0]                     req_rd,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0]      req_wdat,
  output logic [NUM_REQ-1:0]                     gnt,
  output logic [NUM_REQ-1:0]                     ack,
  output logic [BUS_DATA_WIDTH-1:0]              rdat,
  output logic [BUS_ADDR_DATA_LEN-1:0]           addr_dat,
  output logic                                   wr_dat,
  output logic                                   rd_dat,
  output logic [BUS_DATA_WIDTH-1:0]              bus_dat_in,
  input  logic [BUS_DATA_WIDTH-1:0]              bus_dat_out,
  output logic                                   timeout
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state, state_next;
  logic [PTR_W-1:0]    ptr, win_idx;
  logic [NUM_REQ-1:0]  win;
  logic [7:0]          burst_cnt, burst_next;
  logic                own_req, own_wr, own_rd;
  logic                xfer, others, release_now, to_hit;

  pio_rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .req     (req),
    .pointer (ptr),
    .winner  (win)
  );

  // Holder signals are picked with the one-hot grant, so nothing is seen
  // while gnt is 0.
  always_comb begin
    own_req    = |(req    & gnt);
    own_wr     = |(req_wr & gnt);
    own_rd     = |(req_rd & gnt);
    xfer       = (state == ST_OWNED) && (own_wr || own_rd);
    others     = |(req & ~gnt);
    burst_next = burst_cnt;
    if (xfer && burst_cnt != BURST_SAT) begin
      burst_next = burst_cnt + 8'd1;
    end
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  // Next-state logic
  always_comb begin
    release_now = (state == ST_OWNED) &&
                  (!own_req || to_hit ||
                   (xfer && others && burst_next >= 8'(MAX_BURST)));
    state_next = state;
    case (state)
      ST_IDLE:  if (|req)       state_next = ST_OWNED;
      ST_OWNED: if (release_now) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      ack       <= '0;
      rdat      <= '0;
      burst_cnt <= '0;
      ptr       <= PTR_W'(NUM_REQ - 1);
    end else begin
      state <= state_next;
      ack   <= '0;
      if (state == ST_IDLE) begin
        if (|req) begin
          gnt       <= win;
          ptr       <= win_idx;
          burst_cnt <= '0;
        end
      end else begin
        burst_cnt <= burst_next;
        if (xfer) begin
          ack  <= gnt;
          rdat <= bus_dat_out;
        end
        if (release_now) begin
          gnt <= '0;
        end
      end
    end
  end

  // Bus outputs: muxed from the holder's slice, forced to 0 in reset/idle.
  // A simultaneous write and read is issued as a write only.
  always_comb begin
    addr_dat   = '0;
    wr_dat     = 1'b0;
    rd_dat     = 1'b0;
    bus_dat_in = '0;
    if (rst && state == ST_OWNED) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          addr_dat   = req_addr[i*BUS_ADDR_DATA_LEN +: BUS_ADDR_DATA_LEN];
          bus_dat_in = req_wdat[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
      end
      wr_dat = own_wr;
      rd_dat = own_rd & ~own_wr;
    end
  end

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive strobe-less OWNED cycle.
  assign to_hit  = (state == ST_OWNED) && !xfer &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (state != ST_OWNED || xfer || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// Self-checking bench for pio_bus_arbiter (NUM_REQ=2, MAX_BURST=4).
module tb_pio_bus_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned MB = 4;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, req_wr, req_rd;
  logic [15:0] req_addr, req_wdat;
  logic [1:0]  gnt, ack;
  logic [7:0]  rdat, addr_dat, bus_dat_in, bus_dat_out;
  logic        wr_dat, rd_dat, timeout;

  always #5 clk = ~clk;

  pio_bus_arbiter #(
    .NUM_REQ           (NR),
    .BUS_ADDR_DATA_LEN (8),
    .BUS_DATA_WIDTH    (8),
    .MAX_BURST         (MB),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_rd      (req_rd),
    .req_wdat    (req_wdat),
    .gnt         (gnt),
    .ack         (ack),
    .rdat        (rdat),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_dat_out),
    .timeout     (timeout)
  );

  // PIO register file model
  logic [7:0] pio_mem [256];
  logic       mem_init;
  assign bus_dat_out = pio_mem[addr_dat];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) pio_mem[i] <= 8'(i);
    end else if (wr_dat) begin
      pio_mem[addr_dat] <= bus_dat_in;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] ra [2];
  logic [7:0] rw [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] wr,
                       input logic [1:0] rd, input logic [7:0] a0, input logic [7:0] d0,
                       input logic [7:0] a1, input logic [7:0] d1);
    rst = r; req = rq; req_wr = wr; req_rd = rd;
    req_addr = {a1, a0}; req_wdat = {d1, d0};
    ra[0] = a0; ra[1] = a1; rw[0] = d0; rw[1] = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req, wr, rd;
    logic [7:0] a0, d0, a1, d1;
    logic [7:0] e_addr;
    logic       e_wr, e_rd;
    logic [7:0] e_wdat;
    logic [1:0] e_gnt, e_ack;
    logic [7:0] e_rdat;
  } vec_t;

  vec_t vecs [14];

  // Reference model state
  int         m_owner, m_ptr, m_burst, m_idle;
  logic [1:0] e_gnt, e_ack;
  logic [7:0] e_rdat;
  logic       e_to;
  logic [7:0] ref_mem [256];

  task automatic model_step();
    e_ack = '0;
    e_to  = 1'b0;
    if (!rst) begin
      m_owner = -1; m_ptr = NR - 1; m_burst = 0; m_idle = 0;
      e_gnt = '0; e_rdat = '0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (m_ptr + k) % NR;
          if (m_owner < 0 && req[c]) m_owner = c;
        end
        m_ptr = m_owner; m_burst = 0; m_idle = 0;
        e_gnt = 2'(1 << m_owner);
      end
    end else begin
      int o;
      bit strobe, rel;
      o = m_owner;
      strobe = req_wr[o] || req_rd[o];
      rel = !req[o];
      if (strobe) begin
        e_ack  = e_gnt;
        e_rdat = ref_mem[ra[o]];
        if (req_wr[o]) ref_mem[ra[o]] = rw[o];
        if (m_burst < 255) m_burst++;
        m_idle = 0;
        if (m_burst >= MB && (req & ~e_gnt) != 0) rel = 1;
      end else begin
`ifdef PIO_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle >= TO) begin
          rel = 1;
          e_to = 1'b1;
        end
`endif
      end
      if (rel) begin
        m_owner = -1;
        e_gnt = '0;
      end
    end
  endtask

  initial begin
    int n, err;
    logic [1:0] rq;

    // reset, shared-edge request, release gap, write/read to the PIO model,
    // ungranted strobes, release with a final strobe
    //          rst  req    wr     rd     a0     d0     a1     d1     addr  wr    rd    wdat   gnt    ack    rdat
    vecs[0]  = '{1'b0,2'b11,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 8'h00,1'b0,1'b0,8'h00, 2'b00,2'b00,8'h00};
    vecs[1]  = '{1'b1,2'b11,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 8'h00,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h00};
    vecs[2]  = '{1'b1,2'b10,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 8'h00,1'b0,1'b0,8'h00, 2'b00,2'b00,8'h00};
    vecs[3]  = '{1'b1,2'b10,2'b00,2'b00,8'h00,8'h00,8'h33,8'h44, 8'h00,1'b0,1'b0,8'h00, 2'b10,2'b00,8'h00};
    vecs[4]  = '{1'b1,2'b10,2'b00,2'b00,8'h00,8'h00,8'h33,8'h44, 8'h33,1'b0,1'b0,8'h44, 2'b10,2'b00,8'h00};
    vecs[5]  = '{1'b1,2'b00,2'b00,2'b00,8'h00,8'h00,8'h33,8'h44, 8'h33,1'b0,1'b0,8'h44, 2'b00,2'b00,8'h00};
    vecs[6]  = '{1'b1,2'b01,2'b00,2'b00,8'h20,8'hA5,8'h00,8'h00, 8'h00,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h00};
    vecs[7]  = '{1'b1,2'b01,2'b01,2'b00,8'h20,8'hA5,8'h00,8'h00, 8'h20,1'b1,1'b0,8'hA5, 2'b01,2'b01,8'h20};
    vecs[8]  = '{1'b1,2'b01,2'b00,2'b01,8'h20,8'hA5,8'h00,8'h00, 8'h20,1'b0,1'b1,8'hA5, 2'b01,2'b01,8'hA5};
    vecs[9]  = '{1'b1,2'b01,2'b01,2'b01,8'h21,8'h3C,8'h00,8'h00, 8'h21,1'b1,1'b0,8'h3C, 2'b01,2'b01,8'h21};
    vecs[10] = '{1'b1,2'b01,2'b00,2'b01,8'h21,8'h3C,8'h00,8'h00, 8'h21,1'b0,1'b1,8'h3C, 2'b01,2'b01,8'h3C};
    vecs[11] = '{1'b1,2'b01,2'b10,2'b00,8'h21,8'h3C,8'h40,8'hEE, 8'h21,1'b0,1'b0,8'h3C, 2'b01,2'b00,8'h3C};
    vecs[12] = '{1'b1,2'b00,2'b00,2'b01,8'h20,8'h3C,8'h00,8'h00, 8'h20,1'b0,1'b1,8'h3C, 2'b00,2'b01,8'hA5};
    vecs[13] = '{1'b1,2'b00,2'b00,2'b10,8'h00,8'h00,8'h40,8'h00, 8'h00,1'b0,1'b0,8'h00, 2'b00,2'b00,8'hA5};

    mem_init = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    mem_init = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].wr, vecs[i].rd,
            vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d addr_dat", i),   addr_dat,   vecs[i].e_addr);
      chk($sformatf("v%0d wr_dat", i),     wr_dat,     vecs[i].e_wr);
      chk($sformatf("v%0d rd_dat", i),     rd_dat,     vecs[i].e_rd);
      chk($sformatf("v%0d bus_dat_in", i), bus_dat_in, vecs[i].e_wdat);
      tick();
      chk($sformatf("v%0d gnt", i),  gnt,  vecs[i].e_gnt);
      chk($sformatf("v%0d ack", i),  ack,  vecs[i].e_ack);
      chk($sformatf("v%0d rdat", i), rdat, vecs[i].e_rdat);
    end

    // Burst fairness: requester 1 streams writes while requester 0 waits
    drive(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("A grant1", gnt, 2'b10);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 2'b10, 2'b00, 8'h00, 8'h00, 8'(8'h50 + k), 8'(k));
      tick();
      if (ack == 2'b10) n++;
      chk($sformatf("A gnt after xfer%0d", k), gnt, (k == 3) ? 2'b00 : 2'b10);
    end
    chk("A ack count", n, 4);
    chk("A idle wr_dat", wr_dat, 1'b0);
    tick();
    chk("A regrant0", gnt, 2'b01);
    chk("A idle ack", ack, 2'b00);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("A release", gnt, 2'b00);

    // Same stream with no competitor: no forced release
    drive(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("B grant1", gnt, 2'b10);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'b10, 2'b10, 2'b00, 8'h00, 8'h00, 8'(8'h60 + k), 8'(k));
      tick();
      if (ack == 2'b10 && gnt == 2'b10) n++;
    end
    chk("B streak", n, 10);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("B release", gnt, 2'b00);

    // Reset asserted mid-burst
    drive(1'b1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("C grant0", gnt, 2'b01);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'b01, 2'b01, 2'b00, 8'(8'h70 + k), 8'(k), 8'h00, 8'h00);
      tick();
      chk($sformatf("C ack%0d", k), ack, 2'b01);
    end
    drive(1'b0, 2'b01, 2'b01, 2'b00, 8'h72, 8'h99, 8'h00, 8'h00);
    #1;
    chk("C rst addr_dat", addr_dat, 8'h00);
    chk("C rst wr_dat", wr_dat, 1'b0);
    chk("C rst bus_dat_in", bus_dat_in, 8'h00);
    tick();
    chk("C rst gnt", gnt, 2'b00);
    chk("C rst ack", ack, 2'b00);
    chk("C rst rdat", rdat, 8'h00);

    // Strobe-less hold
    drive(1'b1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("D grant0", gnt, 2'b01);
    err = 0;
`ifdef PIO_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        if (gnt != 2'b01 || timeout != 1'b0) err++;
      end else begin
        chk("D timeout gnt", gnt, 2'b00);
        chk("D timeout pulse", timeout, 1'b1);
      end
    end
    chk("D hold before timeout", err, 0);
    tick();
    chk("D pulse width", timeout, 1'b0);
    chk("D regrant", gnt, 2'b01);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gnt != 2'b01 || timeout != 1'b0) err++;
    end
    chk("D hold", err, 0);
`endif
    drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) ref_mem[i] = pio_mem[i];
    rq = 2'b00;
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
      drive(r, rq, 2'($urandom), 2'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom));
      #1;
      if (rst && m_owner >= 0) begin
        chk($sformatf("R%0d addr_dat", i),   addr_dat,   ra[m_owner]);
        chk($sformatf("R%0d wr_dat", i),     wr_dat,     req_wr[m_owner]);
        chk($sformatf("R%0d rd_dat", i),     rd_dat,     req_rd[m_owner] & ~req_wr[m_owner]);
        chk($sformatf("R%0d bus_dat_in", i), bus_dat_in, rw[m_owner]);
      end else begin
        chk($sformatf("R%0d addr_dat", i),   addr_dat,   8'h00);
        chk($sformatf("R%0d wr_dat", i),     wr_dat,     1'b0);
        chk($sformatf("R%0d rd_dat", i),     rd_dat,     1'b0);
        chk($sformatf("R%0d bus_dat_in", i), bus_dat_in, 8'h00);
      end
      model_step();
      tick();
      chk($sformatf("R%0d gnt", i),     gnt,     e_gnt);
      chk($sformatf("R%0d ack", i),     ack,     e_ack);
      chk($sformatf("R%0d rdat", i),    rdat,    e_rdat);
      chk($sformatf("R%0d timeout", i), timeout, e_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
